// File: rtl/esp_stack_controller_if.sv
// Bundles the requester, ALU, ESP-register and data-memory signals of the
// stack controller. "master" is the controller side, "slave" is its environment.
interface esp_stack_controller_if;
    logic        req_a;
    logic [1:0]  op_a;
    logic [31:0] data_a;
    logic [15:0] imm_a;
    logic        req_b;
    logic [31:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic        done_a;
    logic        done_b;
    logic        err;
    logic [31:0] pop_data;
    logic [31:0] esp_in;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_op;
    logic [31:0] alu_result;
    logic [3:0]  esp_wr_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    modport master (
        input  req_a, op_a, data_a, imm_a, req_b, data_b,
        input  esp_in, alu_result, mem_rdata, mem_ready,
        output gnt_a, gnt_b, done_a, done_b, err, pop_data,
        output alu_a, alu_b, alu_op, esp_wr_code,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req_a, op_a, data_a, imm_a, req_b, data_b,
        output esp_in, alu_result, mem_rdata, mem_ready,
        input  gnt_a, gnt_b, done_a, done_b, err, pop_data,
        input  alu_a, alu_b, alu_op, esp_wr_code,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/esp_stack_controller.sv
// ESP stack controller: arbitrates PUSH/POP/ADJ requests, drives the shared
// ALU, runs the data-memory handshake and issues the ESP commit code.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration, latch and limit check at grant
// CALC   | ALU computes the new ESP; registered into new_esp
// MEM    | memory access in flight; bounded by the timeout counter
// COMMIT | esp_wr_code=1 for one cycle, done pulse
// ABORT  | done pulse with err=1, ESP untouched
module esp_stack_controller #(
    parameter logic [31:0] STACK_LIMIT = 32'h0000_1000,
    parameter logic [31:0] STACK_TOP   = 32'h0001_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input logic                    clock,
    input logic                    reset,
    esp_stack_controller_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ADJ  = 2'b10;

    localparam int              TW       = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TMO_LOAD = TW'(MEM_TIMEOUT - 1);
    localparam logic [31:0]     PUSH_MIN = STACK_LIMIT + 32'd4;

    logic [2:0]    state_q, state_d;
    logic          owner_b_q, owner_b_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   delta_q, delta_d;
    logic [31:0]   new_esp_q, new_esp_d;
    logic [31:0]   pop_data_q, pop_data_d;
    logic [1:0]    fair_q, fair_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic idle;
    logic win_a;
    logic win_b;
    logic gnt_a_c;
    logic gnt_b_c;
    logic adj_in_range;

    // Arbitration: b first, unless a has lost twice in a row while waiting.
    // Grants are also masked by reset so every output is quiet while held in reset.
    always_comb begin
        idle    = (state_q == S_IDLE);
        win_b   = bus.req_b && !(bus.req_a && (fair_q >= 2'd2));
        win_a   = bus.req_a && !win_b;
        gnt_a_c = idle && reset && win_a;
        gnt_b_c = idle && reset && win_b;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        owner_b_d  = owner_b_q;
        op_d       = op_q;
        data_d     = data_q;
        delta_d    = delta_q;
        new_esp_d  = new_esp_q;
        pop_data_d = pop_data_q;
        fair_d     = fair_q;
        tmo_d      = (state_q == S_MEM) ? tmo_q : TMO_LOAD;
        adj_in_range = (bus.alu_result >= STACK_LIMIT) && (bus.alu_result <= STACK_TOP);

        case (state_q)
            S_IDLE: begin
                if (gnt_b_c) begin
                    owner_b_d = 1'b1;
                    op_d      = OP_PUSH;
                    data_d    = bus.data_b;
                    delta_d   = 32'd0;
                    fair_d    = bus.req_a ? fair_q + 2'd1 : 2'd0;
                    state_d   = (bus.esp_in < PUSH_MIN) ? S_ABORT : S_CALC;
                end else if (gnt_a_c) begin
                    owner_b_d = 1'b0;
                    data_d    = bus.data_a;
                    fair_d    = 2'd0;
                    case (bus.op_a)
                        OP_PUSH: begin
                            op_d    = OP_PUSH;
                            delta_d = 32'd0;
                            state_d = (bus.esp_in < PUSH_MIN) ? S_ABORT : S_CALC;
                        end
                        OP_POP: begin
                            op_d      = OP_POP;
                            delta_d   = 32'd0;
                            // the pop address is frozen here so it cannot move during MEM
                            new_esp_d = bus.esp_in;
                            state_d   = (bus.esp_in >= STACK_TOP) ? S_ABORT : S_MEM;
                        end
                        OP_ADJ: begin
                            op_d    = OP_ADJ;
                            delta_d = {{16{bus.imm_a[15]}}, bus.imm_a};
                            state_d = S_CALC;
                        end
                        default: begin
                            op_d    = OP_ADJ;
                            delta_d = 32'd0;
                            state_d = S_CALC;
                        end
                    endcase
                end
            end
            S_CALC: begin
                new_esp_d = bus.alu_result;
                case (op_q)
                    OP_PUSH: state_d = S_MEM;
                    OP_POP:  state_d = S_COMMIT;
                    default: state_d = adj_in_range ? S_COMMIT : S_ABORT;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (op_q == OP_POP) begin
                        pop_data_d = bus.mem_rdata;
                        state_d    = S_CALC;
                    end else begin
                        state_d    = S_COMMIT;
                    end
                end else if (tmo_q == '0) begin
                    state_d = S_ABORT;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_b_q  <= 1'b0;
            op_q       <= 2'b00;
            data_q     <= 32'd0;
            delta_q    <= 32'd0;
            new_esp_q  <= 32'd0;
            pop_data_q <= 32'd0;
            fair_q     <= 2'd0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_b_q  <= owner_b_d;
            op_q       <= op_d;
            data_q     <= data_d;
            delta_q    <= delta_d;
            new_esp_q  <= new_esp_d;
            pop_data_q <= pop_data_d;
            fair_q     <= fair_d;
            tmo_q      <= tmo_d;
        end
    end

    // Outputs decoded from state. The ALU operands are held through COMMIT so
    // alu_result still equals new_esp while the ESP register loads it.
    always_comb begin
        bus.gnt_a       = gnt_a_c;
        bus.gnt_b       = gnt_b_c;
        bus.done_a      = ((state_q == S_COMMIT) || (state_q == S_ABORT)) && !owner_b_q;
        bus.done_b      = ((state_q == S_COMMIT) || (state_q == S_ABORT)) && owner_b_q;
        bus.err         = (state_q == S_ABORT);
        bus.busy        = (state_q != S_IDLE);
        bus.pop_data    = pop_data_q;
        bus.esp_wr_code = (state_q == S_COMMIT) ? 4'h1 : 4'h0;
        bus.alu_a       = 32'd0;
        bus.alu_b       = 32'd0;
        bus.alu_op      = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = 32'd0;
        bus.mem_wdata   = 32'd0;

        if ((state_q == S_CALC) || (state_q == S_COMMIT)) begin
            bus.alu_a = bus.esp_in;
            case (op_q)
                OP_PUSH: begin
                    bus.alu_b  = 32'd4;
                    bus.alu_op = 1'b1;
                end
                OP_POP:  bus.alu_b = 32'd4;
                default: bus.alu_b = delta_q;
            endcase
        end

        if (state_q == S_MEM) begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = (op_q == OP_PUSH);
            bus.mem_addr = new_esp_q;
            if (op_q == OP_PUSH) begin
                bus.mem_wdata = data_q;
            end
        end
    end

endmodule

// File: tb/tb_esp_stack_controller.sv
// Self-checking bench for esp_stack_controller: directed cases followed by
// randomized operations, each compared against an outcome model of the stack rules.
module tb_esp_stack_controller;

    localparam logic [31:0] LIMIT = 32'h0000_1000;
    localparam logic [31:0] TOP   = 32'h0001_0000;
    localparam int          TMO   = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    esp_stack_controller_if bus();

    esp_stack_controller #(
        .STACK_LIMIT (LIMIT),
        .STACK_TOP   (TOP),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // combinational ALU of the surrounding datapath
    assign bus.alu_result = bus.alu_op ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

    int vectors    = 0;
    int miscompares = 0;

    int          mem_cycles, stable_bad, commits, code_bad, overlap_bad, cyc, gnt_cyc, done_cyc;
    int          ready_delay;
    bit          mem_seen, mem_we_seen, done_a_seen, done_b_seen, err_seen;
    bit          hold_a, hold_b, esp_pend;
    logic [31:0] mem_addr_seen, mem_wdata_seen, esp_pend_val, rdata_cfg;
    logic [31:0] pop_model = 32'd0;
    bit          gq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        mem_cycles = 0; stable_bad = 0; commits = 0; code_bad = 0; overlap_bad = 0;
        cyc = 0; gnt_cyc = 0; done_cyc = 0;
        mem_seen = 0; done_a_seen = 0; done_b_seen = 0; err_seen = 0;
        gq.delete();
    endtask

    // One clock cycle: observe after inputs settle, answer memory, then cross the
    // rising edge; the ESP register loads a committed value on that edge.
    task automatic step();
        #1;
        cyc++;
        if ((bus.gnt_a || bus.gnt_b) && (bus.done_a || bus.done_b || (bus.gnt_a && bus.gnt_b)))
            overlap_bad++;
        if (bus.gnt_a) begin gq.push_back(1'b0); gnt_cyc = cyc; end
        if (bus.gnt_b) begin gq.push_back(1'b1); gnt_cyc = cyc; end
        if (bus.esp_wr_code != 4'h0) begin
            commits++;
            if (bus.esp_wr_code != 4'h1) code_bad++;
            esp_pend     = 1;
            esp_pend_val = bus.alu_result;
        end
        if (bus.mem_req) begin
            if (!mem_seen) begin
                mem_seen       = 1;
                mem_we_seen    = bus.mem_we;
                mem_addr_seen  = bus.mem_addr;
                mem_wdata_seen = bus.mem_wdata;
            end else if (bus.mem_we !== mem_we_seen || bus.mem_addr !== mem_addr_seen ||
                         (mem_we_seen && bus.mem_wdata !== mem_wdata_seen)) begin
                stable_bad++;
            end
            mem_cycles++;
        end
        bus.mem_ready = bus.mem_req && (ready_delay >= 0) && (mem_cycles > ready_delay);
        bus.mem_rdata = bus.mem_ready ? rdata_cfg : $urandom();
        if (bus.done_a) begin
            done_a_seen = 1; err_seen = bus.err; done_cyc = cyc;
            if (!hold_a) bus.req_a = 1'b0;
        end
        if (bus.done_b) begin
            done_b_seen = 1; err_seen = bus.err; done_cyc = cyc;
            if (!hold_b) bus.req_b = 1'b0;
        end
        @(negedge clock);
        if (esp_pend) begin
            bus.esp_in = esp_pend_val;
            esp_pend   = 0;
        end
    endtask

    // Outcome of one operation from the stack rules alone.
    function automatic void model(input bit is_b, input logic [1:0] op, input logic [31:0] esp,
                                  input logic [15:0] imm, input int rdelay,
                                  output bit ex_abort, output bit ex_mem, output bit ex_we,
                                  output logic [31:0] ex_addr, output logic [31:0] ex_esp,
                                  output bit ex_tmo, output int ex_lat);
        logic [1:0]  eff;
        logic [31:0] delta;
        eff = is_b ? 2'b00 : op;
        ex_abort = 0; ex_mem = 0; ex_we = 0; ex_addr = 32'd0; ex_esp = esp; ex_tmo = 0;
        ex_lat = 0;
        case (eff)
            2'b00: begin
                if (esp < LIMIT + 32'd4) begin ex_abort = 1; ex_lat = 1; end
                else begin ex_mem = 1; ex_we = 1; ex_addr = esp - 32'd4; ex_esp = esp - 32'd4; ex_lat = rdelay + 3; end
            end
            2'b01: begin
                if (esp >= TOP) begin ex_abort = 1; ex_lat = 1; end
                else begin ex_mem = 1; ex_addr = esp; ex_esp = esp + 32'd4; ex_lat = rdelay + 3; end
            end
            default: begin
                delta  = (eff == 2'b10) ? {{16{imm[15]}}, imm} : 32'd0;
                ex_esp = esp + delta;
                ex_lat = 2;
                if (ex_esp < LIMIT || ex_esp > TOP) begin ex_abort = 1; ex_esp = esp; end
            end
        endcase
        if (ex_mem && (rdelay < 0 || rdelay >= TMO)) begin
            ex_abort = 1; ex_tmo = 1; ex_esp = esp;
            ex_lat   = (eff == 2'b00) ? TMO + 2 : TMO + 1;
        end
    endfunction

    task automatic do_op(input string tag, input bit is_b, input logic [1:0] op,
                         input logic [31:0] data, input logic [15:0] imm,
                         input logic [31:0] esp, input int rdelay, input logic [31:0] rdata);
        bit ex_abort, ex_mem, ex_we, ex_tmo;
        logic [31:0] ex_addr, ex_esp;
        int ex_lat;
        model(is_b, op, esp, imm, rdelay, ex_abort, ex_mem, ex_we, ex_addr, ex_esp, ex_tmo, ex_lat);
        clear_obs();
        ready_delay = rdelay; rdata_cfg = rdata; hold_a = 0; hold_b = 0;
        bus.esp_in  = esp;
        if (is_b) begin
            bus.data_b = data; bus.req_b = 1'b1;
        end else begin
            bus.op_a = op; bus.data_a = data; bus.imm_a = imm; bus.req_a = 1'b1;
        end
        for (int i = 0; i < 80 && !(done_a_seen || done_b_seen); i++) step();
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        step();
        check({tag, "/done"}, 32'({done_a_seen, done_b_seen}), is_b ? 32'd1 : 32'd2);
        check({tag, "/ngnt"}, 32'(gq.size()), 32'd1);
        if (gq.size() > 0) check({tag, "/gnt_owner"}, 32'(gq[0]), 32'(is_b));
        check({tag, "/err"}, 32'(err_seen), 32'(ex_abort));
        check({tag, "/commits"}, 32'(commits), ex_abort ? 32'd0 : 32'd1);
        check({tag, "/esp"}, bus.esp_in, ex_esp);
        check({tag, "/code_overlap"}, 32'(code_bad + overlap_bad), 32'd0);
        check({tag, "/mem_seen"}, 32'(mem_seen), 32'(ex_mem));
        if (ex_mem) begin
            check({tag, "/mem_addr"}, mem_addr_seen, ex_addr);
            check({tag, "/mem_we"}, 32'(mem_we_seen), 32'(ex_we));
            if (ex_we) check({tag, "/mem_wdata"}, mem_wdata_seen, data);
            check({tag, "/mem_stable"}, 32'(stable_bad), 32'd0);
            check({tag, "/mem_cycles"}, 32'(mem_cycles), ex_tmo ? 32'(TMO) : 32'(rdelay + 1));
        end
        if (!ex_abort && !is_b && op == 2'b01) pop_model = rdata;
        check({tag, "/pop_data"}, bus.pop_data, pop_model);
        if (done_a_seen || done_b_seen) check({tag, "/latency"}, 32'(done_cyc - gnt_cyc), 32'(ex_lat));
        check({tag, "/busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit          exp_q[$];
        int          cnt;
        bit          is_b;
        logic [1:0]  op;
        logic [31:0] esp;
        int          sel, rd;

        bus.req_a = 1'b1; bus.req_b = 1'b0; bus.op_a = 2'b00; bus.data_a = 32'd0;
        bus.imm_a = 16'd0; bus.data_b = 32'd0; bus.esp_in = 32'h8000;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        hold_a = 0; hold_b = 0; esp_pend = 0; ready_delay = 0; rdata_cfg = 32'd0;

        // reset state, with a request already pending
        #12;
        check("rst/ctrl", 32'({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err, bus.busy,
                                bus.mem_req, bus.mem_we, bus.alu_op, bus.esp_wr_code}), 32'd0);
        check("rst/mem_addr", bus.mem_addr | bus.mem_wdata, 32'd0);
        check("rst/alu", bus.alu_a | bus.alu_b, 32'd0);
        check("rst/pop_data", bus.pop_data, 32'd0);
        bus.req_a = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        // directed cases
        do_op("push",      0, 2'b00, 32'hDEAD_BEEF, 16'h0000, 32'h8000,  2, 32'h0);
        do_op("pop",       0, 2'b01, 32'h0,         16'h0000, 32'h7FFC,  1, 32'h1234_5678);
        do_op("adj_neg",   0, 2'b10, 32'h0,         16'hFFF0, 32'h8000,  0, 32'h0);
        do_op("adj_under", 0, 2'b10, 32'h0,         16'hF000, 32'h1800,  0, 32'h0);
        do_op("push_lim",  0, 2'b00, 32'h5555_AAAA, 16'h0000, 32'h1003,  0, 32'h0);
        do_op("push_edge", 0, 2'b00, 32'hCAFE_F00D, 16'h0000, 32'h1004,  0, 32'h0);
        do_op("pop_top",   0, 2'b01, 32'h0,         16'h0000, 32'h10000, 0, 32'h0BAD_0BAD);
        do_op("pop_edge",  0, 2'b01, 32'h0,         16'h0000, 32'hFFFC,  3, 32'hA5A5_0001);
        do_op("adj_top",   0, 2'b10, 32'h0,         16'h0010, 32'hFFF0,  0, 32'h0);
        do_op("adj_over",  0, 2'b10, 32'h0,         16'h0014, 32'hFFF0,  0, 32'h0);
        do_op("adj_rsvd",  0, 2'b11, 32'h0,         16'h7777, 32'h8000,  0, 32'h0);
        do_op("push_b",    1, 2'b00, 32'h0102_0304, 16'h0000, 32'h4000,  0, 32'h0);
        do_op("tmo_push",  0, 2'b00, 32'h1111_2222, 16'h0000, 32'h8000, -1, 32'h0);
        do_op("tmo_pop",   0, 2'b01, 32'h0,         16'h0000, 32'h8000, -1, 32'h0);

        // fairness with both requesters held continuously
        exp_q.delete();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (cnt >= 2) begin exp_q.push_back(1'b0); cnt = 0; end
            else begin exp_q.push_back(1'b1); cnt++; end
        end
        clear_obs();
        ready_delay = 0; hold_a = 1; hold_b = 1;
        bus.esp_in = 32'h8000; bus.op_a = 2'b10; bus.imm_a = 16'h0000;
        bus.data_b = 32'h7E57_0000; bus.req_a = 1'b1; bus.req_b = 1'b1;
        for (int i = 0; i < 300 && gq.size() < 6; i++) step();
        bus.req_a = 1'b0; bus.req_b = 1'b0; hold_a = 0; hold_b = 0;
        repeat (12) step();
        check("arb/ngnt", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < gq.size()) check($sformatf("arb/order%0d", i), 32'(gq[i]), 32'(exp_q[i]));
        check("arb/overlap", 32'(overlap_bad + code_bad), 32'd0);
        check("arb/busy", 32'(bus.busy), 32'd0);

        // asynchronous reset while a POP waits in MEM
        clear_obs();
        ready_delay = -1;
        bus.esp_in = 32'h7FFC; bus.op_a = 2'b01; bus.req_a = 1'b1;
        for (int i = 0; i < 40 && mem_cycles < 3; i++) step();
        check("rmem/in_mem", 32'(mem_cycles), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("rmem/ctrl", 32'({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err, bus.busy,
                                 bus.mem_req, bus.mem_we, bus.alu_op, bus.esp_wr_code}), 32'd0);
        check("rmem/mem_addr", bus.mem_addr, 32'd0);
        check("rmem/pop_data", bus.pop_data, 32'd0);
        @(posedge clock);
        #1;
        check("rmem/code_hold", 32'({bus.esp_wr_code, bus.busy, bus.gnt_a}), 32'd0);
        bus.req_a = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        pop_model = 32'd0;
        clear_obs();
        ready_delay = 0;
        repeat (6) step();
        check("rmem/after", 32'(commits + mem_cycles + gq.size()), 32'd0);
        check("rmem/esp", bus.esp_in, 32'h7FFC);

        // randomized operations near and away from the stack limits
        for (int n = 0; n < 40; n++) begin
            is_b = ($urandom_range(0, 3) == 0);
            op   = 2'($urandom_range(0, 3));
            sel  = $urandom_range(0, 2);
            if (sel == 0)      esp = LIMIT - 32'd8 + 32'($urandom_range(0, 24));
            else if (sel == 1) esp = TOP - 32'd16 + 32'($urandom_range(0, 24));
            else               esp = 32'($urandom_range(32'h2000, 32'hF000));
            rd = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            do_op($sformatf("rnd%0d", n), is_b, op, $urandom(), 16'($urandom()), esp, rd, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
